// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use detection, multi-cycle EX sequencing,
// memory-wait arbitration, IF/ID flush and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MC_CNT_W   = 4,
  parameter int unsigned PERF_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_reg1addr,
  input  logic                  id_reg1en,
  input  logic [REG_ADDR_W-1:0] id_reg2addr,
  input  logic                  id_reg2en,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwe,
  input  logic                  ex_isload,
  input  logic                  ex_mc_start,
  input  logic [MC_CNT_W-1:0]   ex_mc_cycles,
  input  logic                  mem_stallreq,
  input  logic                  branch_taken,
  output logic [5:0]            stall,
  output logic                  flush_ifid,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_MC   = 6'b001111;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  logic [0:0]          state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic                mc_req;
  logic                mc_done_raw;
  logic                lu;
  logic [5:0]          stall_raw;

  // State, countdown and perf counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Multi-cycle FSM: cnt holds the remaining stall cycles after the current one
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mc_req      = 1'b0;
    mc_done_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_mc_start && !mem_stallreq) begin
          if (ex_mc_cycles >= MC_CNT_W'(2)) begin
            mc_req  = 1'b1;
            state_d = S_BUSY;
            cnt_d   = ex_mc_cycles - MC_CNT_W'(2);
          end else begin
            mc_done_raw = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          mc_req = 1'b1;
          if (!mem_stallreq) begin
            cnt_d = cnt_q - MC_CNT_W'(1);
          end
        end else begin
          mc_done_raw = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lu = ex_isload && ex_regwe && (ex_rd != '0) &&
         ((id_reg1en && (id_reg1addr == ex_rd)) ||
          (id_reg2en && (id_reg2addr == ex_rd)));
  end

  // Stall priority: memory wait > multi-cycle EX > load-use
  always_comb begin
    stall_raw = STALL_NONE;
    if (mem_stallreq) begin
      stall_raw = STALL_MEM;
    end else if (mc_req) begin
      stall_raw = STALL_MC;
    end else if (lu) begin
      stall_raw = STALL_LU;
    end
  end

  always_comb begin
    stall      = rst ? STALL_NONE : stall_raw;
    flush_ifid = !rst && branch_taken && !stall_raw[2];
    mc_done    = !rst && mc_done_raw;
    mc_busy    = !rst && (state_q == S_BUSY);
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall[0] && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl against a cycle-budget reference model.
module tb_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic [4:0] a1;
    logic       e1;
    logic [4:0] a2;
    logic       e2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       start;
    logic [3:0] n;
    logic       mem;
    logic       br;
  } stim_t;

  typedef struct {
    logic [5:0] stall;
    logic       flush;
    logic       busy;
    logic       done;
    longint     perf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_reg1addr, id_reg2addr, ex_rd;
  logic        id_reg1en, id_reg2en, ex_regwe, ex_isload, ex_mc_start;
  logic [3:0]  ex_mc_cycles;
  logic        mem_stallreq, branch_taken;
  logic [5:0]  stall, stall4;
  logic        flush_ifid, flush_ifid4, mc_busy, mc_busy4, mc_done, mc_done4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference model: cycles of EX work left (incl. the done cycle) and total stall count
  bit     m_busy = 1'b0;
  int     m_left = 0;
  longint m_perf = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_CNT_W(4), .PERF_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .id_reg1addr(id_reg1addr), .id_reg1en(id_reg1en),
    .id_reg2addr(id_reg2addr), .id_reg2en(id_reg2en),
    .ex_rd(ex_rd), .ex_regwe(ex_regwe), .ex_isload(ex_isload),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
    .mem_stallreq(mem_stallreq), .branch_taken(branch_taken),
    .stall(stall), .flush_ifid(flush_ifid), .mc_busy(mc_busy),
    .mc_done(mc_done), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.MC_CNT_W(4), .PERF_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .id_reg1addr(id_reg1addr), .id_reg1en(id_reg1en),
    .id_reg2addr(id_reg2addr), .id_reg2en(id_reg2en),
    .ex_rd(ex_rd), .ex_regwe(ex_regwe), .ex_isload(ex_isload),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
    .mem_stallreq(mem_stallreq), .branch_taken(branch_taken),
    .stall(stall4), .flush_ifid(flush_ifid4), .mc_busy(mc_busy4),
    .mc_done(mc_done4), .stall_cycles(stall_cycles4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst: 1'b0, a1: 5'd0, e1: 1'b0, a2: 5'd0, e2: 1'b0, rd: 5'd0, we: 1'b0,
          ld: 1'b0, start: 1'b0, n: 4'd0, mem: 1'b0, br: 1'b0};
    return s;
  endfunction

  // Drive one cycle, push the expected response, then advance the model across the edge
  task automatic apply(input stim_t s);
    exp_t e;
    bit   lu, mcreq, done;
    @(posedge clk);
    #1;
    rst = s.rst; id_reg1addr = s.a1; id_reg1en = s.e1; id_reg2addr = s.a2;
    id_reg2en = s.e2; ex_rd = s.rd; ex_regwe = s.we; ex_isload = s.ld;
    ex_mc_start = s.start; ex_mc_cycles = s.n; mem_stallreq = s.mem; branch_taken = s.br;

    lu = s.ld && s.we && (s.rd != 0) && ((s.e1 && s.a1 == s.rd) || (s.e2 && s.a2 == s.rd));
    mcreq = 1'b0;
    done  = 1'b0;
    if (!m_busy) begin
      if (s.start && !s.mem) begin
        if (int'(s.n) >= 2) mcreq = 1'b1;
        else done = 1'b1;
      end
    end else begin
      if (m_left > 1) mcreq = 1'b1;
      else done = 1'b1;
    end
    if (s.rst)       e.stall = 6'b000000;
    else if (s.mem)  e.stall = 6'b011111;
    else if (mcreq)  e.stall = 6'b001111;
    else if (lu)     e.stall = 6'b000111;
    else             e.stall = 6'b000000;
    e.flush = s.br && !e.stall[2] && !s.rst;
    e.done  = done && !s.rst;
    e.busy  = m_busy && !s.rst;
    e.perf  = m_perf;
    exp_q.push_back(e);

    if (s.rst) begin
      m_busy = 1'b0;
      m_left = 0;
      m_perf = 0;
    end else begin
      if (!m_busy) begin
        if (s.start && !s.mem && int'(s.n) >= 2) begin
          m_busy = 1'b1;
          m_left = int'(s.n) - 1;
        end
      end else if (m_left > 1) begin
        if (!s.mem) m_left--;
      end else begin
        m_busy = 1'b0;
      end
      if (e.stall[0]) m_perf++;
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush_ifid", 32'(flush_ifid), 32'(e.flush));
      chk("mc_busy", 32'(mc_busy), 32'(e.busy));
      chk("mc_done", 32'(mc_done), 32'(e.done));
      chk("stall_cycles", stall_cycles, (e.perf > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(e.perf));
      chk("stall_cycles4", 32'(stall_cycles4), (e.perf > 15) ? 32'd15 : 32'(e.perf));
      chk("stall4", 32'(stall4), 32'(e.stall));
      chk("mc_busy4", 32'(mc_busy4), 32'(e.busy));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst = 1'b1; id_reg1addr = '0; id_reg1en = 1'b0; id_reg2addr = '0; id_reg2en = 1'b0;
    ex_rd = '0; ex_regwe = 1'b0; ex_isload = 1'b0; ex_mc_start = 1'b0;
    ex_mc_cycles = '0; mem_stallreq = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    // Load-use on source 2, then the load has moved on, then rd = 0
    s = idle_stim(); s.ld = 1; s.we = 1; s.rd = 5'd5; s.e2 = 1; s.a2 = 5'd5; apply(s);
    s = idle_stim(); s.e2 = 1; s.a2 = 5'd5; apply(s);
    s = idle_stim(); s.ld = 1; s.we = 1; s.rd = 5'd0; s.e2 = 1; s.a2 = 5'd0; apply(s);

    // Multi-cycle N=4
    s = idle_stim(); s.start = 1; s.n = 4'd4; apply(s);
    repeat (4) apply(idle_stim());

    // N=3 with a memory wait in the second cycle
    s = idle_stim(); s.start = 1; s.n = 4'd3; apply(s);
    s = idle_stim(); s.mem = 1; apply(s);
    repeat (3) apply(idle_stim());

    // N<=1 completes immediately
    s = idle_stim(); s.start = 1; s.n = 4'd1; apply(s);
    s = idle_stim(); s.start = 1; s.n = 4'd0; apply(s);

    // Load-use with branch, then branch alone
    s = idle_stim(); s.ld = 1; s.we = 1; s.rd = 5'd7; s.e1 = 1; s.a1 = 5'd7; s.br = 1; apply(s);
    s = idle_stim(); s.br = 1; apply(s);

    // Reset two cycles into an N=8 op
    s = idle_stim(); s.start = 1; s.n = 4'd8; apply(s);
    apply(idle_stim());
    s = idle_stim(); s.rst = 1; apply(s);
    repeat (2) apply(idle_stim());

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(99) == 0);
      s.a1    = 5'($urandom_range(3));
      s.e1    = 1'($urandom_range(1));
      s.a2    = 5'($urandom_range(3));
      s.e2    = 1'($urandom_range(1));
      s.rd    = 5'($urandom_range(3));
      s.we    = 1'($urandom_range(1));
      s.ld    = 1'($urandom_range(1));
      s.start = ($urandom_range(4) == 0);
      s.n     = 4'($urandom_range(9));
      s.mem   = ($urandom_range(6) == 0);
      s.br    = ($urandom_range(3) == 0);
      apply(s);
    end

    // Long memory wait after reset: 4-bit counter must hold at 15
    s = idle_stim(); s.rst = 1; apply(s);
    s = idle_stim(); s.mem = 1;
    repeat (20) apply(s);
    repeat (2) apply(idle_stim());

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
